// File: rtl/video_timing_pkg.sv
// Shared raster types, FSM encodings and timing helpers for the video timing block.
package video_timing_pkg;
  localparam int CLK_PER_PIXEL = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [1:0] phase;
    logic [9:0] h;
    logic [9:0] v;
  } raster_t;

  // The external scanline bus is 9 bits; lines past 510 read as all-ones.
  function automatic logic [8:0] sat_line(input logic [9:0] v);
    return (v >= 10'd511) ? 9'h1FF : v[8:0];
  endfunction
endpackage

// File: rtl/raster_counter.sv
// Pixel phase, horizontal and vertical counters with wrap strobes.
module raster_counter
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    adv,
  output raster_t pos,
  output raster_t nxt,
  output logic    h_wrap,
  output logic    v_wrap
);
  logic ph_end;

  // nxt is exposed so the top can register its decodes on the same edge.
  always_comb begin
    ph_end = pos.phase == 2'(CLK_PER_PIXEL - 1);
    h_wrap = adv && ph_end && pos.h == 10'(H_TOTAL - 1);
    v_wrap = h_wrap && pos.v == 10'(V_TOTAL - 1);
    nxt    = pos;
    if (rst || !adv) begin
      nxt = '0;
    end else begin
      nxt.phase = ph_end ? 2'd0 : pos.phase + 2'd1;
      if (ph_end) nxt.h = h_wrap ? 10'd0 : pos.h + 10'd1;
      if (h_wrap) nxt.v = v_wrap ? 10'd0 : pos.v + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pos <= '0;
    else     pos <= nxt;
  end
endmodule

// File: rtl/video_timing.sv
// Raster timing generator: counters, sync/blank decode, vblank irq and frame-latched scroll.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cfg_we,
  input  logic       cfg_sel,
  input  logic [9:0] cfg_wdata,
  input  logic       irq_ack,
  output logic [9:0] cycle,
  output logic [8:0] scanline,
  output logic [1:0] pixel_phase,
  output logic       pixel_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       vblank,
  output logic [7:0] frame_count,
  output logic       irq,
  output logic [9:0] scroll_x,
  output logic [8:0] scroll_y
);
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  logic [0:0] state;
  logic       adv, run_nxt, copy, irq_set, h_wrap, v_wrap;
  logic [9:0] shadow_x;
  logic [8:0] shadow_y;
  raster_t    pos, nxt;

  assign run_nxt = !rst && en;
  assign adv     = run_nxt && state == ST_RUN;
  assign copy    = (run_nxt && state == ST_IDLE) || v_wrap;
  assign irq_set = h_wrap && pos.v == 10'(V_VISIBLE - 1);

  raster_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_cnt (
    .clk(clk), .rst(rst), .adv(adv), .pos(pos), .nxt(nxt),
    .h_wrap(h_wrap), .v_wrap(v_wrap)
  );

  assign cycle       = pos.h;
  assign pixel_phase = pos.phase;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= en ? ST_RUN : ST_IDLE;
  end

  // Decodes look at the next counter values so they line up with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      scanline   <= '0;
      pixel_tick <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      active     <= 1'b0;
      vblank     <= 1'b0;
    end else begin
      scanline   <= sat_line(nxt.v);
      pixel_tick <= nxt.phase == 2'(CLK_PER_PIXEL - 1);
      hsync      <= (run_nxt && nxt.h >= 10'(HS_START) && nxt.h <= 10'(HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync      <= (run_nxt && nxt.v >= 10'(VS_START) && nxt.v <= 10'(VS_END)) ? SYNC_POL : ~SYNC_POL;
      active     <= run_nxt && nxt.h < 10'(H_VISIBLE) && nxt.v < 10'(V_VISIBLE);
      vblank     <= nxt.v >= 10'(V_VISIBLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq         <= 1'b0;
      frame_count <= '0;
    end else begin
      if (irq_set)      irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
      if (irq_set) frame_count <= frame_count + 8'd1;
    end
  end

  // Copy samples the pre-write shadow, so a coinciding write lands a frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_x <= '0;
      shadow_y <= '0;
      scroll_x <= '0;
      scroll_y <= '0;
    end else begin
      if (cfg_we && !cfg_sel) shadow_x <= cfg_wdata;
      if (cfg_we && cfg_sel)  shadow_y <= cfg_wdata[8:0];
      if (copy) begin
        scroll_x <= shadow_x;
        scroll_y <= shadow_y;
      end
    end
  end
endmodule

// File: tb/tb_video_timing.sv
// Directed bench: short 8-pixel lines with full 525-line frames, plus a full-width instance.
module tb_video_timing;
  logic       clk = 1'b0;
  logic       rst, en, cfg_we, cfg_sel, irq_ack;
  logic [9:0] cfg_wdata;

  logic [9:0] cycle, scroll_x, cycle_f, scroll_x_f;
  logic [8:0] scanline, scroll_y, scanline_f, scroll_y_f;
  logic [1:0] pixel_phase, pixel_phase_f;
  logic       pixel_tick, hsync, vsync, active, vblank, irq;
  logic       pixel_tick_f, hsync_f, vsync_f, active_f, vblank_f, irq_f;
  logic [7:0] frame_count, frame_count_f;

  int errors = 0;
  int checks = 0;
  int pos    = 0;

  always #5 clk = ~clk;

  // Line = 8 pixels: visible 0..3, front 4, sync 5..6, back 7.
  video_timing #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(480), .V_FRONT(10), .V_SYNC(2), .V_BACK(33), .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .irq_ack(irq_ack), .cycle(cycle), .scanline(scanline),
    .pixel_phase(pixel_phase), .pixel_tick(pixel_tick), .hsync(hsync), .vsync(vsync),
    .active(active), .vblank(vblank), .frame_count(frame_count), .irq(irq),
    .scroll_x(scroll_x), .scroll_y(scroll_y)
  );

  video_timing dut_f (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .irq_ack(irq_ack), .cycle(cycle_f), .scanline(scanline_f),
    .pixel_phase(pixel_phase_f), .pixel_tick(pixel_tick_f), .hsync(hsync_f), .vsync(vsync_f),
    .active(active_f), .vblank(vblank_f), .frame_count(frame_count_f), .irq(irq_f),
    .scroll_x(scroll_x_f), .scroll_y(scroll_y_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic run_to(input int target);
    while (pos < target) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cycle"}, 32'(cycle), 0);
    chk({tag, "_line"}, 32'(scanline), 0);
    chk({tag, "_phase"}, 32'(pixel_phase), 0);
    chk({tag, "_tick"}, 32'(pixel_tick), 0);
    chk({tag, "_hsync"}, 32'(hsync), 1);
    chk({tag, "_vsync"}, 32'(vsync), 1);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_vblank"}, 32'(vblank), 0);
    chk({tag, "_fc"}, 32'(frame_count), 0);
    chk({tag, "_irq"}, 32'(irq), 0);
    chk({tag, "_sx"}, 32'(scroll_x), 0);
    chk({tag, "_sy"}, 32'(scroll_y), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_wdata = '0; irq_ack = 1'b0;
    tick(); tick();
    chk_reset("rst0");
    rst = 1'b0;

    // Load shadows while idle; bit 9 must be dropped for scroll_y.
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 10'h02A; tick();
    cfg_sel = 1'b1; cfg_wdata = 10'h3FF; tick();
    cfg_we = 1'b0;
    chk("idle_sx_held", 32'(scroll_x), 0);
    chk("idle_active", 32'(active), 0);

    en = 1'b1; pos = -1; tick();
    chk("start_cycle", 32'(cycle), 0);
    chk("start_line", 32'(scanline), 0);
    chk("start_phase", 32'(pixel_phase), 0);
    chk("start_active", 32'(active), 1);
    chk("start_tick", 32'(pixel_tick), 0);
    chk("start_sx", 32'(scroll_x), 10'h02A);
    chk("start_sy", 32'(scroll_y), 9'h1FF);
    run_to(3);
    chk("ph3_tick", 32'(pixel_tick), 1);
    chk("ph3_phase", 32'(pixel_phase), 3);
    run_to(4);
    chk("ph0_tick", 32'(pixel_tick), 0);
    chk("ph0_cycle", 32'(cycle), 1);
    run_to(15); chk("act_last", 32'(active), 1);
    run_to(16); chk("act_off", 32'(active), 0);
    run_to(19); chk("hs_pre", 32'(hsync), 1);
    run_to(20); chk("hs_start", 32'(hsync), 0);
    run_to(27); chk("hs_last", 32'(hsync), 0);
    run_to(28); chk("hs_end", 32'(hsync), 1);
    run_to(31); chk("c_last", 32'(cycle), 7);
    run_to(32);
    chk("c_wrap", 32'(cycle), 0);
    chk("c_wrap_line", 32'(scanline), 1);

    // Full 800-pixel line on the default-parameter instance.
    run_to(2623); chk("f_hs_pre", 32'(hsync_f), 1);
    run_to(2624); chk("f_hs_start", 32'(hsync_f), 0);
    run_to(3007); chk("f_hs_last", 32'(hsync_f), 0);
    run_to(3008); chk("f_hs_end", 32'(hsync_f), 1);
    run_to(3199); chk("f_c799", 32'(cycle_f), 799);
    run_to(3200);
    chk("f_c_wrap", 32'(cycle_f), 0);
    chk("f_line1", 32'(scanline_f), 1);

    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 10'h155; tick();
    cfg_we = 1'b0;
    chk("mid_sx_held", 32'(scroll_x), 10'h02A);

    run_to(15359);
    chk("pre_vb_irq", 32'(irq), 0);
    chk("pre_vb_vblank", 32'(vblank), 0);
    irq_ack = 1'b1; tick();
    chk("vb_irq_set_wins", 32'(irq), 1);
    chk("vb_vblank", 32'(vblank), 1);
    chk("vb_fc", 32'(frame_count), 1);
    tick(); irq_ack = 1'b0;
    chk("vb_irq_ack", 32'(irq), 0);

    run_to(15679); chk("vs_pre", 32'(vsync), 1);
    run_to(15680); chk("vs_start", 32'(vsync), 0);
    run_to(15743); chk("vs_last", 32'(vsync), 0);
    run_to(15744); chk("vs_end", 32'(vsync), 1);
    run_to(16351); chk("line510", 32'(scanline), 9'h1FE);
    run_to(16352); chk("line511_sat", 32'(scanline), 9'h1FF);
    run_to(16799);
    chk("line524_sat", 32'(scanline), 9'h1FF);
    chk("eof_sx", 32'(scroll_x), 10'h02A);

    // Write on the copy edge: old shadow is applied now, new one next frame.
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 10'h0AA; tick();
    cfg_we = 1'b0;
    chk("f2_line", 32'(scanline), 0);
    chk("f2_cycle", 32'(cycle), 0);
    chk("f2_sx", 32'(scroll_x), 10'h155);
    chk("f2_sy", 32'(scroll_y), 9'h1FF);
    run_to(33599); chk("f2_end_sx", 32'(scroll_x), 10'h155);
    run_to(33600);
    chk("f3_sx", 32'(scroll_x), 10'h0AA);
    chk("f3_fc", 32'(frame_count), 2);
    chk("f3_irq", 32'(irq), 1);

    run_to(33600 + 200 * 32 + 3 * 4);
    chk("drop_line", 32'(scanline), 200);
    chk("drop_cycle", 32'(cycle), 3);
    en = 1'b0; tick();
    chk("idle_cycle", 32'(cycle), 0);
    chk("idle_line", 32'(scanline), 0);
    chk("idle_phase", 32'(pixel_phase), 0);
    chk("idle_act", 32'(active), 0);
    chk("idle_hs", 32'(hsync), 1);
    chk("idle_vs", 32'(vsync), 1);
    chk("idle_irq_kept", 32'(irq), 1);
    chk("idle_fc_kept", 32'(frame_count), 2);
    en = 1'b1; tick();
    chk("re_cycle", 32'(cycle), 0);
    chk("re_line", 32'(scanline), 0);
    chk("re_phase", 32'(pixel_phase), 0);
    chk("re_active", 32'(active), 1);
    for (int i = 0; i < 41; i++) tick();
    chk("pre_rst_phase", 32'(pixel_phase), 1);
    chk("pre_rst_line", 32'(scanline), 1);

    rst = 1'b1; tick();
    chk_reset("rst1");
    rst = 1'b0; tick();
    chk("post_rst_active", 32'(active), 1);
    chk("post_rst_sx", 32'(scroll_x), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
